tinyalu_arbiter: RTL and testbench

- Two-port round-robin arbiter and sequencer that shares one TinyALU between two requesters.
- Drives the ALU start/op/A/B interface and obeys the TinyALU protocol:
  - operands and op stay stable from start until done;
  - start drops the cycle after done.
- Returns the 16-bit result, with a per-port ack, to the granted requester.
- A watchdog aborts any operation whose done never arrives.

---
 rtl/tinyalu_arbiter.sv | 176 +++++++++++++++++
 tb/tb_tinyalu_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinyalu_arbiter.sv
// rtl/tinyalu_arbiter.sv - round-robin arbiter sequencing two requesters onto one shared TinyALU
module tinyalu_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [2:0]  op0,
    input  logic [7:0]  a0,
    input  logic [7:0]  b0,
    output logic        ack0,
    output logic        err0,
    input  logic        req1,
    input  logic [2:0]  op1,
    input  logic [7:0]  a1,
    input  logic [7:0]  b1,
    output logic        ack1,
    output logic        err1,
    output logic [15:0] result,
    output logic        alu_start,
    output logic [2:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        busy,
    output logic        owner,
    output logic        spurious_done
);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;
    logic        owner_q, owner_d;
    logic        start_q, start_d;
    logic [2:0]  op_q, op_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] result_q, result_d;
    logic [1:0]  ack_q, ack_d;
    logic [1:0]  err_q, err_d;
    logic        busy_q, busy_d;
    logic        spurious_q, spurious_d;

    logic        any_req;
    logic        grant;
    logic [2:0]  sel_op;
    logic [7:0]  sel_a;
    logic [7:0]  sel_b;
    logic        timeout_hit;
    logic [1:0]  owner_onehot;

    // On a tie the port that did not win last time is served.
    assign any_req      = req0 | req1;
    assign grant        = (req0 & req1) ? ~last_grant_q : req1;
    assign sel_op       = grant ? op1 : op0;
    assign sel_a        = grant ? a1 : a0;
    assign sel_b        = grant ? b1 : b0;
    assign timeout_hit  = (cnt_q == TIMEOUT_LAST);
    assign owner_onehot = owner_q ? 2'b10 : 2'b01;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            start_q      <= 1'b0;
            op_q         <= 3'd0;
            a_q          <= 8'd0;
            b_q          <= 8'd0;
            result_q     <= 16'd0;
            ack_q        <= 2'b00;
            err_q        <= 2'b00;
            busy_q       <= 1'b0;
            spurious_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            start_q      <= start_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            result_q     <= result_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            spurious_q   <= spurious_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req) state_d = (sel_op == 3'b000) ? S_DONE : S_BUSY;
            S_BUSY:  if (alu_done || timeout_hit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        start_d      = start_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        result_d     = result_q;
        ack_d        = 2'b00;
        err_d        = 2'b00;
        spurious_d   = spurious_q | (alu_done & ~start_q);
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    owner_d      = grant;
                    last_grant_d = grant;
                    op_d         = sel_op;
                    a_d          = sel_a;
                    b_d          = sel_b;
                    cnt_d        = 8'd0;
                    // A no_op never touches the ALU and completes straight away.
                    if (sel_op == 3'b000) begin
                        result_d = 16'd0;
                        ack_d    = grant ? 2'b10 : 2'b01;
                    end else begin
                        start_d = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                if (alu_done) begin
                    result_d = alu_result;
                    start_d  = 1'b0;
                    ack_d    = owner_onehot;
                    cnt_d    = 8'd0;
                end else if (timeout_hit) begin
                    result_d = 16'd0;
                    start_d  = 1'b0;
                    ack_d    = owner_onehot;
                    err_d    = owner_onehot;
                    cnt_d    = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE:  start_d = 1'b0;
            default: start_d = 1'b0;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign ack0          = ack_q[0];
    assign ack1          = ack_q[1];
    assign err0          = err_q[0];
    assign err1          = err_q[1];
    assign result        = result_q;
    assign alu_start     = start_q;
    assign alu_op        = op_q;
    assign alu_a         = a_q;
    assign alu_b         = b_q;
    assign busy          = busy_q;
    assign owner         = owner_q;
    assign spurious_done = spurious_q;

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// tb/tb_tinyalu_arbiter.sv - self-checking bench for tinyalu_arbiter with a behavioural TinyALU
module tb_tinyalu_arbiter;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [2:0]  op0, op1;
    logic [7:0]  a0, b0, a1, b1;
    logic        ack0, err0, ack1, err1;
    logic [15:0] result;
    logic        alu_start;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a, alu_b;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        busy, owner, spurious_done;

    int checks   = 0;
    int failures = 0;
    int alu_lat  = 0;
    int alu_cnt  = 0;

    always #5 clk = ~clk;

    tinyalu_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0), .ack0(ack0), .err0(err0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1), .ack1(ack1), .err1(err1),
        .result(result),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result),
        .busy(busy), .owner(owner), .spurious_done(spurious_done)
    );

    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd1:    return 16'(a) + 16'(b);
            3'd2:    return {8'h00, a & b};
            3'd3:    return {8'h00, a ^ b};
            3'd4:    return 16'(a) * 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    // Advance one cycle; the TinyALU answers alu_lat cycles into a start (0 = never).
    task automatic step();
        @(posedge clk);
        #1;
        if (alu_start && alu_lat != 0) begin
            alu_cnt = alu_cnt + 1;
            if (alu_cnt == alu_lat) begin
                alu_done   = 1'b1;
                alu_result = alu_fn(alu_op, alu_a, alu_b);
            end else begin
                alu_done = 1'b0;
            end
        end else begin
            alu_cnt  = 0;
            alu_done = 1'b0;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; alu_done = 1'b0; alu_lat = 0; alu_cnt = 0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        step();
        checks++;
        if ({alu_start, busy, owner, ack0, ack1, err0, err1, spurious_done} !== 8'h00) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000000", {alu_start, busy, owner, ack0, ack1, err0, err1, spurious_done});
        end
        checks++;
        if (result !== 16'h0000) begin failures++; $display("FAIL reset_result got=%h exp=0000", result); end
        checks++;
        if ({alu_op, alu_a, alu_b} !== 19'h0) begin failures++; $display("FAIL reset_alu_bus got=%h exp=0", {alu_op, alu_a, alu_b}); end
        reset = 1'b0;
        step();
        checks++;
        if ({alu_start, busy, ack0, ack1} !== 4'b0000) begin
            failures++; $display("FAIL idle_after_reset got=%b exp=0000", {alu_start, busy, ack0, ack1});
        end
    endtask

    task automatic test_single_add();
        int hi; bit seen; bit stable; logic [15:0] r; logic e, other;
        hi = 0; seen = 0; stable = 1; r = 'x; e = 'x; other = 'x;
        step();
        alu_lat = 3;
        req0 = 1'b1; op0 = 3'b001; a0 = 8'hFF; b0 = 8'h01;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (ack0) begin
                seen = 1; r = result; e = err0; other = ack1 | alu_start; req0 = 1'b0;
            end else if (alu_start) begin
                hi++;
                if ({alu_op, alu_a, alu_b} !== {3'b001, 8'hFF, 8'h01}) stable = 0;
            end
            step();
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL add_ack_timeout got=none exp=ack0"); end
        checks++;
        if (hi != 3) begin failures++; $display("FAIL add_start_cycles got=%0d exp=3", hi); end
        checks++;
        if (r !== 16'h0100) begin failures++; $display("FAIL add_result got=%h exp=0100", r); end
        checks++;
        if ({e, other} !== 2'b00) begin failures++; $display("FAIL add_err_ack1_start got=%b exp=00", {e, other}); end
        checks++;
        if (!stable) begin failures++; $display("FAIL add_operand_stable got=changed exp=stable"); end
        checks++;
        if ({ack0, busy} !== 2'b00) begin failures++; $display("FAIL add_ack_single_pulse got=%b exp=00", {ack0, busy}); end
    endtask

    task automatic test_contention();
        int n; int port [2]; logic [15:0] res [2]; logic own [2];
        int low_run; int min_gap; bit started; bit prev;
        n = 0; low_run = 0; min_gap = 99; started = 0; prev = 0;
        apply_reset();
        alu_lat = 2;
        req0 = 1'b1; op0 = 3'b100; a0 = 8'd12; b0 = 8'd10;
        req1 = 1'b1; op1 = 3'b100; a1 = 8'd12; b1 = 8'd10;
        for (int i = 0; i < 60 && n < 2; i++) begin
            if (ack0 || ack1) begin
                port[n] = ack1 ? (ack0 ? 2 : 1) : 0;
                res[n]  = result;
                own[n]  = owner;
                if (ack0) req0 = 1'b0;
                if (ack1) req1 = 1'b0;
                n++;
            end
            if (alu_start) begin
                if (!prev && started && low_run < min_gap) min_gap = low_run;
                started = 1; low_run = 0;
            end else begin
                low_run++;
            end
            prev = alu_start;
            step();
        end
        checks++;
        if (n != 2) begin failures++; $display("FAIL contention_ack_count got=%0d exp=2", n); end
        else begin
            checks++;
            if (port[0] != 0 || port[1] != 1) begin
                failures++; $display("FAIL contention_order got=%0d,%0d exp=0,1", port[0], port[1]);
            end
            checks++;
            if (res[0] !== 16'd120 || res[1] !== 16'd120) begin
                failures++; $display("FAIL contention_result got=%0d,%0d exp=120,120", res[0], res[1]);
            end
            checks++;
            if ({own[0], own[1]} !== 2'b01) begin failures++; $display("FAIL contention_owner got=%b exp=01", {own[0], own[1]}); end
        end
        checks++;
        if (min_gap < 2 || min_gap == 99) begin failures++; $display("FAIL contention_start_gap got=%0d exp>=2", min_gap); end
    endtask

    task automatic test_noop();
        int hi; int at; bit seen; logic [15:0] r; logic e, other;
        hi = 0; at = -1; seen = 0; r = 'x; e = 'x; other = 'x;
        step();
        alu_lat = 1;
        req1 = 1'b1; op1 = 3'b000; a1 = 8'($urandom); b1 = 8'($urandom);
        for (int i = 0; i < 10 && !seen; i++) begin
            if (ack1) begin seen = 1; at = i; r = result; e = err1; other = ack0; req1 = 1'b0; end
            if (alu_start) hi++;
            step();
        end
        checks++;
        if (at != 1) begin failures++; $display("FAIL noop_ack_latency got=%0d exp=1", at); end
        checks++;
        if (hi != 0) begin failures++; $display("FAIL noop_alu_start got=%0d exp=0", hi); end
        checks++;
        if ({r, e, other} !== 18'h0) begin failures++; $display("FAIL noop_result_err got=%h exp=0", {r, e, other}); end
    endtask

    task automatic test_timeout();
        int hi; bit seen; logic [15:0] r; logic e; int n; int port [2];
        hi = 0; seen = 0; r = 'x; e = 'x; n = 0;
        step();
        alu_lat = 0;
        req0 = 1'b1; op0 = 3'b001; a0 = 8'($urandom); b0 = 8'($urandom);
        for (int i = 0; i < 40 && !seen; i++) begin
            if (ack0) begin seen = 1; r = result; e = err0; req0 = 1'b0; end
            if (alu_start) hi++;
            step();
        end
        checks++;
        if (hi != TIMEOUT) begin failures++; $display("FAIL timeout_start_cycles got=%0d exp=%0d", hi, TIMEOUT); end
        checks++;
        if ({seen, e} !== 2'b11) begin failures++; $display("FAIL timeout_err got=%b exp=11", {seen, e}); end
        checks++;
        if (r !== 16'h0000) begin failures++; $display("FAIL timeout_result got=%h exp=0000", r); end
        checks++;
        if ({err0, ack0, busy} !== 3'b000) begin failures++; $display("FAIL timeout_cleared got=%b exp=000", {err0, ack0, busy}); end
        step();
        alu_lat = 2;
        req0 = 1'b1; op0 = 3'b010; a0 = 8'($urandom); b0 = 8'($urandom);
        req1 = 1'b1; op1 = 3'b011; a1 = 8'($urandom); b1 = 8'($urandom);
        for (int i = 0; i < 40 && n < 2; i++) begin
            if (ack0 || ack1) begin
                port[n] = ack1 ? 1 : 0;
                if (ack0) req0 = 1'b0;
                if (ack1) req1 = 1'b0;
                n++;
            end
            step();
        end
        checks++;
        if (n != 2 || port[0] != 1 || port[1] != 0) begin
            failures++; $display("FAIL timeout_next_grant got=n%0d first=%0d exp=n2 first=1", n, port[0]);
        end
    endtask

    task automatic test_reset_mid_op();
        int n; int port [2]; logic [15:0] res [2]; logic [7:0] xa, xb;
        n = 0; xa = 8'($urandom); xb = 8'($urandom);
        step();
        alu_lat = 0;
        req0 = 1'b1; op0 = 3'b100; a0 = 8'd7; b0 = 8'd9;
        step();
        step();
        checks++;
        if ({busy, alu_start} !== 2'b11) begin failures++; $display("FAIL rst_mid_busy got=%b exp=11", {busy, alu_start}); end
        #2;
        reset = 1'b1;
        req0  = 1'b0;
        #1;
        checks++;
        if ({alu_start, busy, ack0, ack1} !== 4'b0000) begin
            failures++; $display("FAIL rst_mid_async got=%b exp=0000", {alu_start, busy, ack0, ack1});
        end
        step();
        reset = 1'b0;
        alu_lat = 1;
        req1 = 1'b1; op1 = 3'b011; a1 = xa; b1 = xb;
        step();
        checks++;
        if ({owner, alu_start} !== 2'b11) begin failures++; $display("FAIL rst_mid_grant1 got=%b exp=11", {owner, alu_start}); end
        req0 = 1'b1; op0 = 3'b001; a0 = 8'd200; b0 = 8'd100;
        for (int i = 0; i < 40 && n < 2; i++) begin
            if (ack0 || ack1) begin
                port[n] = ack1 ? 1 : 0; res[n] = result;
                if (ack0) req0 = 1'b0;
                if (ack1) req1 = 1'b0;
                n++;
            end
            step();
        end
        checks++;
        if (n != 2 || port[0] != 1 || port[1] != 0) begin
            failures++; $display("FAIL rst_mid_order got=n%0d first=%0d exp=n2 first=1", n, port[0]);
        end else begin
            checks++;
            if (res[0] !== {8'h00, xa ^ xb} || res[1] !== 16'd300) begin
                failures++; $display("FAIL rst_mid_results got=%h,%h exp=%h,012c", res[0], res[1], {8'h00, xa ^ xb});
            end
        end
    endtask

    task automatic test_random();
        bit exp_last; logic [1:0] mask; int order [2]; int n_exp;
        logic [2:0] t_op [2]; logic [7:0] t_a [2]; logic [7:0] t_b [2];
        int low_run;
        apply_reset();
        exp_last = 1;
        for (int r = 0; r < 30; r++) begin
            step();
            for (int e = $urandom_range(0, 2); e > 0; e--) step();
            low_run = 100;
            mask = 2'($urandom_range(1, 3));
            for (int p = 0; p < 2; p++) begin
                t_op[p] = 3'($urandom_range(0, 4)); t_a[p] = 8'($urandom); t_b[p] = 8'($urandom);
            end
            req0 = mask[0]; op0 = t_op[0]; a0 = t_a[0]; b0 = t_b[0];
            req1 = mask[1]; op1 = t_op[1]; a1 = t_a[1]; b1 = t_b[1];
            if (mask == 2'b11) begin order[0] = exp_last ? 0 : 1; order[1] = exp_last ? 1 : 0; n_exp = 2; end
            else begin order[0] = (mask == 2'b10) ? 1 : 0; n_exp = 1; end
            exp_last = order[n_exp - 1][0];
            for (int k = 0; k < n_exp; k++) begin
                int p; int lat; int sel; int hi; bit seen; bit stable; int exp_hi; logic [15:0] exp_res; logic [1:0] exp_ack;
                p = order[k]; sel = $urandom_range(0, 9);
                lat = (sel == 0) ? 0 : (sel == 1) ? TIMEOUT : $urandom_range(1, 5);
                alu_lat = lat; hi = 0; seen = 0; stable = 1;
                exp_ack = (p == 1) ? 2'b10 : 2'b01;
                if (t_op[p] == 3'b000) begin exp_hi = 0; exp_res = 16'h0; end
                else if (lat == 0) begin exp_hi = TIMEOUT; exp_res = 16'h0; end
                else begin exp_hi = lat; exp_res = alu_fn(t_op[p], t_a[p], t_b[p]); end
                for (int i = 0; i < 40 && !seen; i++) begin
                    if (ack0 || ack1) begin
                        seen = 1;
                        checks++;
                        if ({ack1, ack0} !== exp_ack || owner !== p[0]) begin
                            failures++; $display("FAIL rnd_ack_port r%0d got=%b own=%b exp=%b", r, {ack1, ack0}, owner, exp_ack);
                        end
                        checks++;
                        if ({err1, err0} !== ((t_op[p] != 0 && lat == 0) ? exp_ack : 2'b00)) begin
                            failures++; $display("FAIL rnd_err r%0d got=%b op=%0d lat=%0d", r, {err1, err0}, t_op[p], lat);
                        end
                        checks++;
                        if (result !== exp_res) begin failures++; $display("FAIL rnd_result r%0d got=%h exp=%h", r, result, exp_res); end
                        checks++;
                        if (hi != exp_hi) begin failures++; $display("FAIL rnd_start_cycles r%0d got=%0d exp=%0d", r, hi, exp_hi); end
                        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
                    end else if (alu_start) begin
                        hi++;
                        if (hi == 1) begin
                            checks++;
                            if ({alu_op, alu_a, alu_b} !== {t_op[p], t_a[p], t_b[p]}) begin
                                failures++; $display("FAIL rnd_latched r%0d got=%h exp=%h", r, {alu_op, alu_a, alu_b}, {t_op[p], t_a[p], t_b[p]});
                            end
                            if (k == 1) begin
                                checks++;
                                if (low_run < 2) begin failures++; $display("FAIL rnd_start_gap r%0d got=%0d exp>=2", r, low_run); end
                            end
                            if (p == 0) begin op0 = 3'($urandom); a0 = 8'($urandom); b0 = 8'($urandom); end
                            else begin op1 = 3'($urandom); a1 = 8'($urandom); b1 = 8'($urandom); end
                        end else if ({alu_op, alu_a, alu_b} !== {t_op[p], t_a[p], t_b[p]}) begin
                            stable = 0;
                        end
                    end
                    low_run = alu_start ? 0 : low_run + 1;
                    step();
                end
                checks++;
                if (!seen) begin failures++; $display("FAIL rnd_ack_timeout r%0d k%0d got=none exp=ack", r, k); end
                if (t_op[p] != 3'b000) begin
                    checks++;
                    if (!stable) begin failures++; $display("FAIL rnd_operand_stable r%0d got=changed exp=stable", r); end
                end
            end
        end
    endtask

    task automatic test_stray_done();
        bit seen; logic [15:0] r; logic e;
        seen = 0; r = 'x; e = 'x;
        step();
        checks++;
        if (spurious_done !== 1'b0) begin failures++; $display("FAIL stray_pre got=%b exp=0", spurious_done); end
        alu_done = 1'b1; alu_result = 16'hDEAD;
        step();
        checks++;
        if ({spurious_done, ack0, ack1, busy} !== 4'b1000) begin
            failures++; $display("FAIL stray_set got=%b exp=1000", {spurious_done, ack0, ack1, busy});
        end
        step(); step(); step();
        checks++;
        if (spurious_done !== 1'b1) begin failures++; $display("FAIL stray_sticky got=%b exp=1", spurious_done); end
        alu_lat = 2;
        req1 = 1'b1; op1 = 3'b011; a1 = 8'h5A; b1 = 8'h0F;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (ack1) begin seen = 1; r = result; e = err1; req1 = 1'b0; end
            step();
        end
        checks++;
        if ({seen, e, r} !== {1'b1, 1'b0, 16'h0055}) begin
            failures++; $display("FAIL stray_followup got=%b%b_%h exp=10_0055", seen, e, r);
        end
        checks++;
        if (spurious_done !== 1'b1) begin failures++; $display("FAIL stray_sticky_end got=%b exp=1", spurious_done); end
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; op0 = 3'd0; a0 = 8'd0; b0 = 8'd0;
        req1 = 1'b0; op1 = 3'd0; a1 = 8'd0; b1 = 8'd0;
        alu_done = 1'b0; alu_result = 16'd0;
        test_reset();
        test_single_add();
        test_contention();
        test_noop();
        test_timeout();
        test_reset_mid_op();
        test_random();
        test_stray_done();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
